// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared states, opcodes, ALU and bus select codes for the accumulator CPU
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH_0,
        S_FETCH_1,
        S_FETCH_2,
        S_DECODE_3,
        S_IMM_4,
        S_IMM_5,
        S_DIR_4,
        S_DIR_5,
        S_DIR_6,
        S_DIR_7,
        S_ALU_4,
        S_BR_4,
        S_BR_5,
        S_BRN_4
    } state_t;

    localparam logic [7:0] LDA_IMM = 8'h86;
    localparam logic [7:0] LDA_DIR = 8'h87;
    localparam logic [7:0] LDB_IMM = 8'h88;
    localparam logic [7:0] LDB_DIR = 8'h89;
    localparam logic [7:0] STA_DIR = 8'h96;
    localparam logic [7:0] STB_DIR = 8'h97;

    localparam logic [7:0] ADD_AB  = 8'h42;
    localparam logic [7:0] SUB_AB  = 8'h43;
    localparam logic [7:0] AND_AB  = 8'h44;
    localparam logic [7:0] OR_AB   = 8'h45;
    localparam logic [7:0] XOR_AB  = 8'h46;
    localparam logic [7:0] INCA    = 8'h47;
    localparam logic [7:0] DECA    = 8'h48;
    localparam logic [7:0] NOTA    = 8'h49;

    localparam logic [7:0] BRA     = 8'h20;
    localparam logic [7:0] BMI     = 8'h21;
    localparam logic [7:0] BPL     = 8'h22;
    localparam logic [7:0] BEQ     = 8'h23;
    localparam logic [7:0] BNE     = 8'h24;
    localparam logic [7:0] BVS     = 8'h25;
    localparam logic [7:0] BVC     = 8'h26;
    localparam logic [7:0] BCS     = 8'h27;
    localparam logic [7:0] BCC     = 8'h28;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_INC = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_DEC = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;
    localparam logic [2:0] ALU_NOT = 3'b111;

    localparam logic [1:0] BUS1_PC   = 2'b00;
    localparam logic [1:0] BUS1_A    = 2'b01;
    localparam logic [1:0] BUS1_B    = 2'b10;
    localparam logic [1:0] BUS2_ALU  = 2'b00;
    localparam logic [1:0] BUS2_BUS1 = 2'b01;
    localparam logic [1:0] BUS2_MEM  = 2'b10;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    // Map an ALU-class opcode onto the ALU operation code
    function automatic logic [2:0] alu_sel_of(input logic [7:0] op);
        logic [2:0] sel;
        sel = ALU_ADD;
        case (op)
            ADD_AB:  sel = ALU_ADD;
            SUB_AB:  sel = ALU_SUB;
            AND_AB:  sel = ALU_AND;
            OR_AB:   sel = ALU_OR;
            XOR_AB:  sel = ALU_XOR;
            INCA:    sel = ALU_INC;
            DECA:    sel = ALU_DEC;
            NOTA:    sel = ALU_NOT;
            default: sel = ALU_ADD;
        endcase
        return sel;
    endfunction

    function automatic logic is_alu_op(input logic [7:0] op);
        return (op >= ADD_AB) && (op <= NOTA);
    endfunction

    function automatic logic is_branch_op(input logic [7:0] op);
        return (op >= BRA) && (op <= BCC);
    endfunction

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - branch taken decision from opcode and latched NZVC flags
module branch_cond
    import cpu_pkg::*;
(
    input  logic [7:0] i_ir,
    input  logic [3:0] i_ccr,
    output logic       o_take
);

    // Select the flag test for each conditional branch; non-branches never take
    always_comb begin
        o_take = 1'b0;
        case (i_ir)
            BRA:     o_take = 1'b1;
            BMI:     o_take =  i_ccr[FLAG_N];
            BPL:     o_take = ~i_ccr[FLAG_N];
            BEQ:     o_take =  i_ccr[FLAG_Z];
            BNE:     o_take = ~i_ccr[FLAG_Z];
            BVS:     o_take =  i_ccr[FLAG_V];
            BVC:     o_take = ~i_ccr[FLAG_V];
            BCS:     o_take =  i_ccr[FLAG_C];
            BCC:     o_take = ~i_ccr[FLAG_C];
            default: o_take = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - fetch/decode/execute sequencer driving datapath strobes and selects
module control_unit
    import cpu_pkg::*;
#(
    parameter int IR_WIDTH = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [IR_WIDTH-1:0] IR,
    input  logic [3:0]          CCR_Result,
    output logic                IR_Load,
    output logic                MAR_Load,
    output logic                PC_Load,
    output logic                PC_Inc,
    output logic                A_Load,
    output logic                B_Load,
    output logic [2:0]          ALU_Sel,
    output logic                CCR_Load,
    output logic [1:0]          Bus1_Sel,
    output logic [1:0]          Bus2_Sel,
    output logic                write
);

    state_t r_state;
    state_t w_next;
    logic   w_take;

    branch_cond u_branch_cond (
        .i_ir   (IR),
        .i_ccr  (CCR_Result),
        .o_take (w_take)
    );

    // State register; reset drops straight back to the first fetch state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH_0;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection and Moore/opcode output decode
    always_comb begin
        w_next   = S_FETCH_0;
        IR_Load  = 1'b0;
        MAR_Load = 1'b0;
        PC_Load  = 1'b0;
        PC_Inc   = 1'b0;
        A_Load   = 1'b0;
        B_Load   = 1'b0;
        ALU_Sel  = ALU_ADD;
        CCR_Load = 1'b0;
        Bus1_Sel = BUS1_PC;
        Bus2_Sel = BUS2_ALU;
        write    = 1'b0;
        case (r_state)
            S_FETCH_0: begin
                MAR_Load = 1'b1;
                Bus1_Sel = BUS1_PC;
                Bus2_Sel = BUS2_BUS1;
                w_next   = S_FETCH_1;
            end
            S_FETCH_1: begin
                PC_Inc = 1'b1;
                w_next = S_FETCH_2;
            end
            S_FETCH_2: begin
                Bus2_Sel = BUS2_MEM;
                IR_Load  = 1'b1;
                w_next   = S_DECODE_3;
            end
            S_DECODE_3: begin
                if (IR == LDA_IMM || IR == LDB_IMM) begin
                    w_next = S_IMM_4;
                end else if (IR == LDA_DIR || IR == LDB_DIR ||
                             IR == STA_DIR || IR == STB_DIR) begin
                    w_next = S_DIR_4;
                end else if (is_alu_op(IR)) begin
                    w_next = S_ALU_4;
                end else if (is_branch_op(IR)) begin
                    w_next = w_take ? S_BR_4 : S_BRN_4;
                end else begin
                    w_next = S_FETCH_0;
                end
            end
            S_IMM_4, S_DIR_4, S_BR_4: begin
                MAR_Load = 1'b1;
                Bus1_Sel = BUS1_PC;
                Bus2_Sel = BUS2_BUS1;
                w_next   = (r_state == S_IMM_4) ? S_IMM_5 :
                           (r_state == S_DIR_4) ? S_DIR_5 : S_BR_5;
            end
            S_IMM_5: begin
                Bus2_Sel = BUS2_MEM;
                A_Load   = (IR == LDA_IMM);
                B_Load   = (IR == LDB_IMM);
                PC_Inc   = 1'b1;
                w_next   = S_FETCH_0;
            end
            S_DIR_5: begin
                PC_Inc = 1'b1;
                w_next = S_DIR_6;
            end
            S_DIR_6: begin
                Bus2_Sel = BUS2_MEM;
                MAR_Load = 1'b1;
                w_next   = S_DIR_7;
            end
            S_DIR_7: begin
                if (IR == STA_DIR || IR == STB_DIR) begin
                    Bus1_Sel = (IR == STA_DIR) ? BUS1_A : BUS1_B;
                    write    = 1'b1;
                end else begin
                    Bus2_Sel = BUS2_MEM;
                    A_Load   = (IR == LDA_DIR);
                    B_Load   = (IR == LDB_DIR);
                end
                w_next = S_FETCH_0;
            end
            S_ALU_4: begin
                Bus1_Sel = BUS1_B;
                Bus2_Sel = BUS2_ALU;
                ALU_Sel  = alu_sel_of(IR);
                A_Load   = 1'b1;
                CCR_Load = 1'b1;
                w_next   = S_FETCH_0;
            end
            S_BR_5: begin
                Bus2_Sel = BUS2_MEM;
                PC_Load  = 1'b1;
                w_next   = S_FETCH_0;
            end
            S_BRN_4: begin
                PC_Inc = 1'b1;
                w_next = S_FETCH_0;
            end
            default: w_next = S_FETCH_0;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for the control unit against an instruction-level model
module tb_control_unit;

    logic       clock;
    logic       reset;
    logic [7:0] IR;
    logic [3:0] CCR_Result;
    logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write;
    logic [2:0] ALU_Sel;
    logic [1:0] Bus1_Sel, Bus2_Sel;

    control_unit #(.IR_WIDTH(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .IR         (IR),
        .CCR_Result (CCR_Result),
        .IR_Load    (IR_Load),
        .MAR_Load   (MAR_Load),
        .PC_Load    (PC_Load),
        .PC_Inc     (PC_Inc),
        .A_Load     (A_Load),
        .B_Load     (B_Load),
        .ALU_Sel    (ALU_Sel),
        .CCR_Load   (CCR_Load),
        .Bus1_Sel   (Bus1_Sel),
        .Bus2_Sel   (Bus2_Sel),
        .write      (write)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    wire [14:0] w_act = {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load,
                         ALU_Sel, CCR_Load, Bus1_Sel, Bus2_Sel, write};

    int n_cmp  = 0;
    int n_fail = 0;

    logic [14:0] exp_q[$];
    logic [7:0]  op_q[$];

    function automatic logic [14:0] v(input bit irl, input bit marl, input bit pcl,
                                      input bit pci, input bit al, input bit bl,
                                      input logic [2:0] alu, input bit ccrl,
                                      input logic [1:0] b1, input logic [1:0] b2,
                                      input bit wr);
        return {irl, marl, pcl, pci, al, bl, alu, ccrl, b1, b2, wr};
    endfunction

    // Reference model: per-cycle strobe vectors for one whole instruction
    task automatic model_instr(input logic [7:0] op, input logic [3:0] ccr,
                               output int len, input int limit);
        logic [14:0] q[$];
        logic [14:0] mar_pc;
        logic [2:0]  alu_codes[8];
        int          k;
        bit          taken;
        alu_codes = '{3'd0, 3'd2, 3'd4, 3'd5, 3'd6, 3'd1, 3'd3, 3'd7};
        mar_pc = v(0,1,0,0,0,0,3'd0,0,2'd0,2'd1,0);
        q.push_back(mar_pc);
        q.push_back(v(0,0,0,1,0,0,3'd0,0,2'd0,2'd0,0));
        q.push_back(v(1,0,0,0,0,0,3'd0,0,2'd0,2'd2,0));
        q.push_back(15'd0);
        if (op == 8'h86 || op == 8'h88) begin
            q.push_back(mar_pc);
            q.push_back(v(0,0,0,1,op==8'h86,op==8'h88,3'd0,0,2'd0,2'd2,0));
        end else if (op == 8'h87 || op == 8'h89 || op == 8'h96 || op == 8'h97) begin
            q.push_back(mar_pc);
            q.push_back(v(0,0,0,1,0,0,3'd0,0,2'd0,2'd0,0));
            q.push_back(v(0,1,0,0,0,0,3'd0,0,2'd0,2'd2,0));
            if (op == 8'h87 || op == 8'h89)
                q.push_back(v(0,0,0,0,op==8'h87,op==8'h89,3'd0,0,2'd0,2'd2,0));
            else
                q.push_back(v(0,0,0,0,0,0,3'd0,0,(op==8'h96)?2'd1:2'd2,2'd0,1));
        end else if (op >= 8'h42 && op <= 8'h49) begin
            k = int'(op) - 8'h42;
            q.push_back(v(0,0,0,0,1,0,alu_codes[k],1,2'd2,2'd0,0));
        end else if (op >= 8'h20 && op <= 8'h28) begin
            k = int'(op) - 8'h20;
            taken = (k == 0) || (ccr[3 - (k - 1) / 2] == ((k % 2) == 1));
            if (taken) begin
                q.push_back(mar_pc);
                q.push_back(v(0,0,1,0,0,0,3'd0,0,2'd0,2'd2,0));
            end else begin
                q.push_back(v(0,0,0,1,0,0,3'd0,0,2'd0,2'd0,0));
            end
        end
        len = q.size();
        for (int i = 0; i < q.size() && i < limit; i++) begin
            exp_q.push_back(q[i]);
            op_q.push_back(op);
        end
    endtask

    // Issue one instruction starting in the first fetch state
    task automatic run_instr(input logic [7:0] op, input logic [3:0] ccr);
        int len;
        IR = op;
        CCR_Result = ccr;
        model_instr(op, ccr, len, 100);
        repeat (len) @(posedge clock);
        #1;
    endtask

    // Monitor: every sampled cycle out of reset consumes one expected vector
    always @(negedge clock) begin
        if (reset && exp_q.size() > 0) begin
            logic [14:0] e;
            logic [7:0]  o;
            e = exp_q.pop_front();
            o = op_q.pop_front();
            n_cmp++;
            if (w_act !== e) begin
                n_fail++;
                $display("FAIL strobes op=%02h actual=%015b required=%015b", o, w_act, e);
            end
        end
    end

    logic [7:0] ops[23];

    initial begin
        int len;
        logic [7:0] op;
        ops = '{8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97,
                8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49,
                8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
        reset = 1'b0;
        IR = 8'h00;
        CCR_Result = 4'h0;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++;
        if (w_act !== v(0,1,0,0,0,0,3'd0,0,2'd0,2'd1,0)) begin
            n_fail++;
            $display("FAIL reset_state actual=%015b", w_act);
        end
        reset = 1'b1;

        run_instr(8'h86, 4'h0);
        run_instr(8'h43, 4'hF);
        run_instr(8'h23, 4'b0100);
        run_instr(8'h23, 4'b0000);
        run_instr(8'h97, 4'h0);
        run_instr(8'hFF, 4'h0);

        // LDA_DIR abandoned by reset while in S_6
        IR = 8'h87;
        CCR_Result = 4'h0;
        model_instr(8'h87, 4'h0, len, 7);
        repeat (6) @(posedge clock);
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (w_act !== v(0,1,0,0,0,0,3'd0,0,2'd0,2'd1,0)) begin
            n_fail++;
            $display("FAIL async_reset actual=%015b", w_act);
        end
        @(posedge clock);
        #1;
        n_cmp++;
        if (w_act !== v(0,1,0,0,0,0,3'd0,0,2'd0,2'd1,0) || A_Load !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold actual=%015b", w_act);
        end
        reset = 1'b1;

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) op = 8'($urandom_range(0, 255));
            else op = ops[$urandom_range(0, 22)];
            run_instr(op, 4'($urandom_range(0, 15)));
        end

        repeat (2) @(posedge clock);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
